// File: rtl/ex_mac_seq_if.sv
// Operand/result bundle between the EX stage and the multi-cycle MAC engine.
// master = EX-stage driver, slave = ex_mac_seq.
interface ex_mac_seq_if;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic [63:0] hilo_i;
    logic        flush_i;
    logic        hold_i;
    logic        stallreq_o;
    logic        busy_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start_i, op_i, opa_i, opb_i, hilo_i, flush_i, hold_i,
        input  stallreq_o, busy_o, whilo_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, opa_i, opb_i, hilo_i, flush_i, hold_i,
        output stallreq_o, busy_o, whilo_o, hi_o, lo_o
    );
endinterface

// File: rtl/ex_mac_seq.sv
// Iterative MADD/MADDU/MSUB/MSUBU engine: HI/LO +/- opa*opb, K_BITS multiplier bits per cycle.
// Define MAC_EARLY_TERM_EN to leave MUL as soon as the remaining multiplier bits are zero.
module ex_mac_seq #(
    parameter int K_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    ex_mac_seq_if.slave mac
);
    localparam int N  = 32 / K_BITS;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    state_t        state, state_nx;
    logic          sub_q;
    logic          neg_q;
    logic [63:0]   hilo_q;
    logic [31:0]   mcand_q;
    logic [31:0]   mplier_q;
    logic [63:0]   prod_q;
    logic [63:0]   result_q;
    logic [CW-1:0] cnt_q;

    logic          accept;
    logic          mul_last;
    logic [31:0]   mplier_sh;
    logic [63:0]   pp;
    logic [63:0]   p_signed;
    logic          stallreq, whilo;
    logic [31:0]   hi, lo;

    assign accept    = mac.start_i & ~mac.flush_i;
    assign mplier_sh = mplier_q >> K_BITS;
    assign pp        = (64'(mcand_q) * 64'(mplier_q[K_BITS-1:0])) << (cnt_q * K_BITS);
    assign p_signed  = neg_q ? (~prod_q + 64'd1) : prod_q;

`ifdef MAC_EARLY_TERM_EN
    assign mul_last = (cnt_q == LAST) || (mplier_sh == 32'd0);
`else
    assign mul_last = (cnt_q == LAST);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stallreq = 1'b0;
        whilo    = 1'b0;
        hi       = 32'd0;
        lo       = 32'd0;
        case (state)
            IDLE: begin
                stallreq = accept;
                if (accept) state_nx = MUL;
            end
            MUL: begin
                stallreq = 1'b1;
                if (mul_last) state_nx = ACC;
            end
            ACC: begin
                stallreq = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                // A flush landing on DONE kills the write in that same cycle.
                whilo = ~mac.flush_i;
                hi    = result_q[63:32];
                lo    = result_q[31:0];
                if (!mac.hold_i) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (mac.flush_i) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q    <= 1'b0;
            neg_q    <= 1'b0;
            hilo_q   <= 64'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            prod_q   <= 64'd0;
            result_q <= 64'd0;
            cnt_q    <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sub_q  <= mac.op_i[1];
                    hilo_q <= mac.hilo_i;
                    prod_q <= 64'd0;
                    cnt_q  <= '0;
                    // Signed ops multiply magnitudes; sign is reapplied in ACC.
                    if (mac.op_i[0]) begin
                        mcand_q  <= mac.opa_i[31] ? (~mac.opa_i + 32'd1) : mac.opa_i;
                        mplier_q <= mac.opb_i[31] ? (~mac.opb_i + 32'd1) : mac.opb_i;
                        neg_q    <= mac.opa_i[31] ^ mac.opb_i[31];
                    end else begin
                        mcand_q  <= mac.opa_i;
                        mplier_q <= mac.opb_i;
                        neg_q    <= 1'b0;
                    end
                end
                MUL: begin
                    prod_q   <= prod_q + pp;
                    mplier_q <= mplier_sh;
                    cnt_q    <= cnt_q + 1'b1;
                end
                ACC: result_q <= sub_q ? (hilo_q - p_signed) : (hilo_q + p_signed);
                default: ;
            endcase
        end
    end

    assign mac.stallreq_o = stallreq;
    assign mac.busy_o     = (state != IDLE);
    assign mac.whilo_o    = whilo;
    assign mac.hi_o       = hi;
    assign mac.lo_o       = lo;
endmodule
